// File: rtl/supply_bank_pkg.sv
// Shared definitions for the supply register bank.
//   state_t     : two-phase request FSM (IDLE accepts, EXEC performs the update)
//   OP_VEND     : latched op value for a customer vend
//   OP_RESTOCK  : latched op value for an owner restock
//   sat_add_ok  : overflow flag of a + b when the result must fit in w bits
package supply_bank_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  localparam logic OP_VEND    = 1'b0;
  localparam logic OP_RESTOCK = 1'b1;

  // Returns 1 when a + b does not fit in w bits. One extra bit of headroom
  // is kept so the carry out of the top supply bit is never lost.
  function automatic logic sat_add_ok(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input int unsigned w);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >> w) != 33'd0;
  endfunction

endpackage

// File: rtl/supply_bank_slot.sv
// One product slot of the supply bank.
//   clk, rst_n : clock and synchronous active-low reset (reset loads INIT_SUPPLY)
//   i_inc      : add i_qty to the stored count (caller has already ruled out overflow)
//   i_dec      : subtract one (caller has already ruled out an empty slot)
//   i_qty      : restock quantity
//   o_value    : stored supply count
//   o_isZero   : stored count is zero; comes straight off the register
module supply_slot #(
  parameter int SUP_W       = 4,
  parameter int INIT_SUPPLY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic [SUP_W-1:0] i_qty,
  output logic [SUP_W-1:0] o_value,
  output logic             o_isZero
);

  logic [SUP_W-1:0] r_value;

  // Increment and decrement are never requested together; increment wins
  // anyway so the behaviour stays defined if that ever changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_value <= SUP_W'(INIT_SUPPLY);
    end else if (i_inc) begin
      r_value <= r_value + i_qty;
    end else if (i_dec) begin
      r_value <= r_value - 1'b1;
    end
  end

  assign o_value  = r_value;
  assign o_isZero = (r_value == '0);

endmodule

// File: rtl/supply_bank.sv
// Per-product supply register bank sitting behind the owner restock stage.
//   clk, rst_n     : clock, synchronous active-low reset
//   mode           : 1 = owner restock, 0 = customer vend (sampled at accept)
//   req_valid/ready: request handshake; one request every two cycles
//   req_id, req_qty: target product and restock quantity
//   done           : one-cycle pulse when the latched request has completed
//   vend_ok        : vend result, valid with done and held until the next done
//   redlight       : last restock overflowed or targeted a bad id
//   sold_out       : bit i set when slot i holds zero
//   rd_id          : combinational read address for machine_supply
//   machine_supply : supply of slot rd_id, zero for an out-of-range id
module supply_bank
  import supply_bank_pkg::*;
#(
  parameter int NUM_PRODUCTS = 4,
  parameter int SUP_W        = 4,
  parameter int ID_W         = 2,
  parameter int INIT_SUPPLY  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ID_W-1:0]         req_id,
  input  logic [SUP_W-1:0]        req_qty,
  output logic                    done,
  output logic                    vend_ok,
  output logic                    redlight,
  output logic [NUM_PRODUCTS-1:0] sold_out,
  input  logic [ID_W-1:0]         rd_id,
  output logic [SUP_W-1:0]        machine_supply
);

  state_t            r_state;
  state_t            w_nextState;
  logic [ID_W-1:0]   r_id;
  logic [SUP_W-1:0]  r_qty;
  logic              r_op;
  logic              r_done;
  logic              r_vendOk;
  logic              r_redlight;

  logic              w_exec;
  logic              w_inRange;
  logic              w_overflow;
  logic [SUP_W-1:0]  w_curSupply;
  logic [SUP_W-1:0]  w_slotValue [NUM_PRODUCTS];
  logic [NUM_PRODUCTS-1:0] w_inc;
  logic [NUM_PRODUCTS-1:0] w_dec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_nextState = EXEC;
      EXEC:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  assign req_ready = (r_state == IDLE);
  assign w_exec    = (r_state == EXEC);

  // The op is captured at accept so a mode change during EXEC is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_id  <= '0;
      r_qty <= '0;
      r_op  <= OP_VEND;
    end else if (req_ready && req_valid) begin
      r_id  <= req_id;
      r_qty <= req_qty;
      r_op  <= mode;
    end
  end

  // Slot addressed by the latched request; an id with no matching slot
  // leaves w_inRange low so nothing downstream gets written.
  always_comb begin
    w_curSupply = '0;
    w_inRange   = 1'b0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (r_id == ID_W'(i)) begin
        w_curSupply = w_slotValue[i];
        w_inRange   = 1'b1;
      end
    end
  end

  assign w_overflow = sat_add_ok(32'(w_curSupply), 32'(r_qty), SUP_W);

  // Result flags: vend_ok follows every completion, redlight only restocks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done     <= 1'b0;
      r_vendOk   <= 1'b0;
      r_redlight <= 1'b0;
    end else begin
      r_done <= w_exec;
      if (w_exec) begin
        r_vendOk <= (r_op == OP_VEND) && w_inRange && (w_curSupply != '0);
        if (r_op == OP_RESTOCK) begin
          r_redlight <= !w_inRange || w_overflow;
        end
      end
    end
  end

  assign done     = r_done;
  assign vend_ok  = r_vendOk;
  assign redlight = r_redlight;

  for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : gSlot
    assign w_inc[g] = w_exec && (r_op == OP_RESTOCK) && (r_id == ID_W'(g)) && !w_overflow;
    assign w_dec[g] = w_exec && (r_op == OP_VEND) && (r_id == ID_W'(g)) && (w_curSupply != '0);

    supply_slot #(
      .SUP_W       (SUP_W),
      .INIT_SUPPLY (INIT_SUPPLY)
    ) uSlot (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_inc    (w_inc[g]),
      .i_dec    (w_dec[g]),
      .i_qty    (r_qty),
      .o_value  (w_slotValue[g]),
      .o_isZero (sold_out[g])
    );
  end

  always_comb begin
    machine_supply = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (rd_id == ID_W'(i)) machine_supply = w_slotValue[i];
    end
  end

endmodule

// File: tb/tb_supply_bank.sv
// Self-checking bench for supply_bank: a 4-slot bank driven with directed
// and random requests against a plain-arithmetic inventory model, plus a
// 3-slot bank for the out-of-range id behaviour.
module tb_supply_bank;

  localparam int NP   = 4;
  localparam int MAXS = 15;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_id;
  logic [3:0]  req_qty;
  logic        done;
  logic        vend_ok;
  logic        redlight;
  logic [3:0]  sold_out;
  logic [1:0]  rd_id;
  logic [3:0]  machine_supply;

  logic        mode3;
  logic        valid3;
  logic        ready3;
  logic [1:0]  id3;
  logic [3:0]  qty3;
  logic        done3;
  logic        vendOk3;
  logic        red3;
  logic [2:0]  soldOut3;
  logic [1:0]  rd3;
  logic [3:0]  supply3;

  int total = 0;
  int bad   = 0;

  int   model [NP];
  logic expVendOk;
  logic expRed;

  supply_bank #(.NUM_PRODUCTS(4), .SUP_W(4), .ID_W(2), .INIT_SUPPLY(0)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .req_valid(req_valid),
    .req_ready(req_ready), .req_id(req_id), .req_qty(req_qty), .done(done),
    .vend_ok(vend_ok), .redlight(redlight), .sold_out(sold_out),
    .rd_id(rd_id), .machine_supply(machine_supply)
  );

  supply_bank #(.NUM_PRODUCTS(3), .SUP_W(4), .ID_W(2), .INIT_SUPPLY(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .req_valid(valid3),
    .req_ready(ready3), .req_id(id3), .req_qty(qty3), .done(done3),
    .vend_ok(vendOk3), .redlight(red3), .sold_out(soldOut3),
    .rd_id(rd3), .machine_supply(supply3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inventory rules: restock only when the total still fits, vend only
  // from a non-empty slot.
  task automatic modelApply(input logic op, input int id, input int qty);
    if (op) begin
      expVendOk = 1'b0;
      if (id >= NP || model[id] + qty > MAXS) begin
        expRed = 1'b1;
      end else begin
        model[id] = model[id] + qty;
        expRed    = 1'b0;
      end
    end else begin
      if (id < NP && model[id] > 0) begin
        model[id] = model[id] - 1;
        expVendOk = 1'b1;
      end else begin
        expVendOk = 1'b0;
      end
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NP; i++) model[i] = 0;
    expVendOk = 1'b0;
    expRed    = 1'b0;
  endtask

  task automatic checkState(input string tag);
    logic [3:0] expSold;
    for (int i = 0; i < NP; i++) expSold[i] = (model[i] == 0);
    checkOutput({tag, "_vend_ok"}, vend_ok, expVendOk);
    checkOutput({tag, "_redlight"}, redlight, expRed);
    checkOutput({tag, "_sold_out"}, sold_out, expSold);
    for (int i = 0; i < NP; i++) begin
      rd_id = 2'(i);
      #1;
      checkOutput($sformatf("%s_supply%0d", tag, i), machine_supply, model[i]);
    end
  endtask

  // Issues one request from IDLE (entered 1 time unit after an edge) and
  // checks the accept cycle, the done cycle and the cycle after.
  task automatic applyStimulus(input string tag, input logic m, input int id,
                               input int qty, input logic flip);
    checkOutput({tag, "_ready_idle"}, req_ready, 1'b1);
    mode      = m;
    req_id    = 2'(id);
    req_qty   = 4'(qty);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (flip) mode = ~m;
    modelApply(m, id, qty);
    checkOutput({tag, "_ready_exec"}, req_ready, 1'b0);
    checkOutput({tag, "_done_early"}, done, 1'b0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done"}, done, 1'b1);
    checkState(tag);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_once"}, done, 1'b0);
  endtask

  initial begin
    int dones;
    int m, id, qty;

    rst_n = 1'b0; mode = 1'b0; req_valid = 1'b0; req_id = '0; req_qty = '0; rd_id = '0;
    mode3 = 1'b0; valid3 = 1'b0; id3 = '0; qty3 = '0; rd3 = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    checkOutput("rst_ready", req_ready, 1'b1);
    checkOutput("rst_done", done, 1'b0);
    checkState("rst");

    // Restock with and without overflow
    applyStimulus("rs9", 1'b1, 2, 9, 1'b0);
    applyStimulus("rs7ovf", 1'b1, 2, 7, 1'b0);
    applyStimulus("rs6full", 1'b1, 2, 6, 1'b0);
    applyStimulus("rs0qty", 1'b1, 2, 0, 1'b0);

    // Vend from an empty slot, then a single item twice
    applyStimulus("vempty", 1'b0, 1, 0, 1'b0);
    applyStimulus("rs1", 1'b1, 1, 1, 1'b0);
    applyStimulus("vlast", 1'b0, 1, 0, 1'b0);
    applyStimulus("vagain", 1'b0, 1, 0, 1'b0);

    // req_valid held high: accepts every second cycle
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1;
      mode      = 1'b1;
      req_id    = 2'(c >> 1);
      req_qty   = 4'($urandom_range(0, 7));
      checkOutput($sformatf("b2b_ready%0d", c), req_ready, (c % 2) == 0);
      if (req_ready) modelApply(1'b1, c >> 1, int'(req_qty));
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    req_valid = 1'b0;
    checkOutput("b2b_dones", dones, 4);
    checkState("b2b");
    @(posedge clk);
    #1;

    // Mode flipped during EXEC: the latched restock still completes
    applyStimulus("flip", 1'b1, 0, 3, 1'b1);
    applyStimulus("afterflip", 1'b0, 0, 0, 1'b0);

    // Reset during EXEC aborts the restock
    mode = 1'b1; req_id = 2'd0; req_qty = 4'd5; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_ready", req_ready, 1'b1);
    checkState("abort");
    @(posedge clk);
    #1;
    checkOutput("abort_done_late", done, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 40; n++) begin
      m   = $urandom_range(0, 1);
      id  = $urandom_range(0, NP - 1);
      qty = $urandom_range(0, 15);
      applyStimulus($sformatf("rnd%0d", n), m[0], id, qty, 1'b0);
    end

    // Three-slot bank: id 3 has no slot
    checkOutput("n3_ready", ready3, 1'b1);
    mode3 = 1'b1; id3 = 2'd3; qty3 = 4'd4; valid3 = 1'b1;
    @(posedge clk);
    #1;
    valid3 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("n3_bad_done", done3, 1'b1);
    checkOutput("n3_bad_red", red3, 1'b1);
    checkOutput("n3_bad_sold", soldOut3, 3'b111);
    for (int i = 0; i < 4; i++) begin
      rd3 = 2'(i);
      #1;
      checkOutput($sformatf("n3_bad_supply%0d", i), supply3, 0);
    end
    @(posedge clk);
    #1;
    id3 = 2'd2; valid3 = 1'b1;
    @(posedge clk);
    #1;
    valid3 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("n3_ok_red", red3, 1'b0);
    checkOutput("n3_ok_sold", soldOut3, 3'b011);
    rd3 = 2'd2;
    #1;
    checkOutput("n3_ok_supply2", supply3, 4);
    rd3 = 2'd3;
    #1;
    checkOutput("n3_ok_supply3", supply3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/supply_bank.md
Name: supply_bank

Overview:
- Per-product supply register bank directly downstream of the owner restock stage.
- Holds the current supply count of every product.
- Applies owner restock requests, which add quantity with an overflow check and raise redlight.
- Applies customer vend requests, which decrement, or reject when the product is sold out.
- Drives the machine_supply value consumed by the owner/vend logic, and per-product sold_out flags for the display.

Parameters:
- NUM_PRODUCTS, 4, number of product slots. Must be ≥2.
- SUP_W, 4, width of each supply count. Maximum supply is 2^SUP_W-1.
- ID_W, 2, width of product id. Must satisfy 2^ID_W ≥ NUM_PRODUCTS.
- INIT_SUPPLY, 0, value loaded into every slot on reset.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- mode  in  1  1 = owner mode (restock only), 0 = customer mode (vend only).
- req_valid  in  1  request present.
- req_ready  out  1  bank can accept a request.
- req_id  in  ID_W  target product.
- req_qty  in  SUP_W  restock quantity. Ignored for vend.
- done  out  1  one-cycle pulse when the latched request has completed.
- vend_ok  out  1  valid with done for a vend: 1 = item dispensed, 0 = rejected.
- redlight  out  1  result of the last restock: 1 = overflow or bad id. Held until the next restock completes.
- sold_out  out  NUM_PRODUCTS  bit i = 1 when slot i holds 0. Registered.
- rd_id  in  ID_W  combinational read address.
- machine_supply  out  SUP_W  supply of slot rd_id. Reads 0 if rd_id ≥ NUM_PRODUCTS.

Behaviour:
- Reset (rst_n=0 at an edge):
  - all slots = INIT_SUPPLY; state = IDLE.
  - req_ready=1, done=0, vend_ok=0, redlight=0.
  - sold_out = all 1s if INIT_SUPPLY==0, else all 0s.
  - Reset during EXEC aborts the operation: no write, no done.
- FSM states are IDLE and EXEC.
  - IDLE: req_ready=1. Handshake occurs when req_valid && req_ready at edge k. At that edge the bank latches id, qty and op (op = mode at edge k), and moves to EXEC.
  - EXEC: req_ready=0. At edge k+1 the bank performs the read-modify-write, updates sold_out, asserts done for exactly one cycle, and returns to IDLE.
  - Throughput is one request per 2 cycles. Back-to-back: a new request may be accepted at edge k+2.
- Restock (op=1):
  - sum = {1'b0,slot} + {1'b0,qty}, computed in SUP_W+1 bits.
  - If sum > 2^SUP_W-1: slot unchanged, redlight=1.
  - Otherwise: slot = sum[SUP_W-1:0], redlight=0.
  - qty=0 is legal: slot unchanged, redlight=0.
  - vend_ok=0 on the done cycle.
- Vend (op=0):
  - If slot > 0: slot -= 1, vend_ok=1.
  - If slot == 0: slot unchanged, vend_ok=0, no wrap to 2^SUP_W-1.
  - redlight is unchanged.
- Id out of range (id ≥ NUM_PRODUCTS): no slot is written and done still pulses.
  - Restock: redlight=1.
  - Vend: vend_ok=0.
- A mode change while in EXEC has no effect. The latched op completes.
- vend_ok holds its value until the next done. redlight changes only on restock completion or reset.
- machine_supply is combinational from the slot array. It reflects the write from edge k+1 in the cycle after that edge.
- sold_out is updated at the same edge as the slot write.

Decomposition:
- Shared package:
  - FSM state enum {IDLE, EXEC}.
  - OP_VEND=0, OP_RESTOCK=1.
  - Function sat_add_ok(a, b), returning the overflow flag at SUP_W.
- One natural sub-module: supply_slot. It holds one SUP_W register with inc-by-qty, dec and load-init, and exposes is_zero. NUM_PRODUCTS instances are generated in supply_bank.

Test Plan:
All scenarios use the defaults NUM_PRODUCTS=4, SUP_W=4, INIT_SUPPLY=0.
1. Reset, then read all slots → machine_supply=0 for every rd_id; sold_out=4'b1111; redlight=0; req_ready=1.
2. mode=1, restock id 2 qty 9 → done one cycle after accept; slot2=9; redlight=0; sold_out=4'b1011. Then restock id 2 qty 7 (9+7=16) → slot2 stays 9, redlight=1. Then restock id 2 qty 6 → slot2=15, redlight=0.
3. mode=0, vend id 1 with slot1=0 → vend_ok=0, slot1 stays 0 (no wrap to 15). Restock id 1 qty 1, then vend id 1 twice → first vend_ok=1 with slot1=0 and sold_out[1]=1; second vend_ok=0.
4. Hold req_valid high continuously with alternating ids → accepts occur every 2nd cycle, req_ready=0 in EXEC; 4 requests give exactly 4 done pulses.
5. Accept a restock with mode=1, flip mode to 0 during EXEC → restock still completes (slot += qty, vend_ok=0). The next accepted request is a vend.
6. Accept a restock of qty 5 on id 0, assert rst_n=0 on the following edge → no done pulse; slot0=0; redlight=0; state IDLE. Separately, id=3 is valid when NUM_PRODUCTS=4; rerun with NUM_PRODUCTS=3 and restock id 3 → redlight=1 with no slot changed.
